// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard/sequencing controller.
//
// Pipeline -> controller:
//   RsD, RtD            decode-stage source registers
//   RsE, RtE            execute-stage source registers
//   WriteRegE/M/W       destination register of the E, M and W stages
//   RegWriteE/M/W       stage writes the register file
//   MemtoRegE/M         stage holds a load
//   BranchD, PCSrcD     branch comparing / branch or jump taken in decode
//   MdStartE, MdOpE     execute holds a mul/div; 0 = multiply, 1 = divide
// Controller -> pipeline:
//   ForwardAE/BE        ALU operand select (00 regfile, 01 WB, 10 MEM ALU)
//   ForwardAD/BD        branch comparator takes the MEM ALU result
//   StallF/D/E          hold PC, IF-ID, ID-EX
//   FlushD/E/M          bubble IF-ID, ID-EX, EX-MEM
//   MdBusy, MdDone      mul/div sequencer active / release-cycle pulse
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;

    logic [4:0] RsD;
    logic [4:0] RtD;
    logic [4:0] RsE;
    logic [4:0] RtE;
    logic [4:0] WriteRegE;
    logic [4:0] WriteRegM;
    logic [4:0] WriteRegW;
    logic       RegWriteE;
    logic       RegWriteM;
    logic       RegWriteW;
    logic       MemtoRegE;
    logic       MemtoRegM;
    logic       BranchD;
    logic       PCSrcD;
    logic       MdStartE;
    logic       MdOpE;

    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;
    logic       ForwardAD;
    logic       ForwardBD;
    logic       StallF;
    logic       StallD;
    logic       StallE;
    logic       FlushD;
    logic       FlushE;
    logic       FlushM;
    logic       MdBusy;
    logic       MdDone;

    // Pipeline side: drives register numbers and stage flags, consumes controls.
    modport master (
        output RsD, RtD, RsE, RtE,
        output WriteRegE, WriteRegM, WriteRegW,
        output RegWriteE, RegWriteM, RegWriteW,
        output MemtoRegE, MemtoRegM,
        output BranchD, PCSrcD,
        output MdStartE, MdOpE,
        input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
        input  StallF, StallD, StallE,
        input  FlushD, FlushE, FlushM,
        input  MdBusy, MdDone
    );

    // Controller side.
    modport slave (
        input  RsD, RtD, RsE, RtE,
        input  WriteRegE, WriteRegM, WriteRegW,
        input  RegWriteE, RegWriteM, RegWriteW,
        input  MemtoRegE, MemtoRegM,
        input  BranchD, PCSrcD,
        input  MdStartE, MdOpE,
        output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
        output StallF, StallD, StallE,
        output FlushD, FlushE, FlushM,
        output MdBusy, MdDone
    );

endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard and sequencing controller for the 5-stage core. Produces the operand
// forwarding selects, load-use / branch-compare stalls, pipeline flushes, and
// holds a multi-cycle multiply/divide in execute for a fixed latency.
//
// Ports:
//   clk    core clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   hz     hazard_ctrl_if.slave (see interface for signal list)
//
// All forward/stall/flush/MdBusy/MdDone outputs are combinational from the
// interface inputs and the sequencer state; only the sequencer is registered.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32,
    parameter int unsigned CNT_W   = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);

    localparam int unsigned REG_W = 5;

    // Counter preload: hold lasts LAT cycles including the start cycle.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } mdState_t;

    mdState_t         mdState;
    mdState_t         mdStateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;

    logic mdHold;
    logic mdDone;
    logic lwStall;
    logic branchStall;
    logic hazStall;

    // Register 0 is hard-wired, so it never creates a dependence.
    function automatic logic regMatch(input logic [REG_W-1:0] a,
                                      input logic [REG_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    // Execute-stage operand select; memory stage holds the younger value.
    function automatic logic [1:0] fwdSel(input logic [REG_W-1:0] src,
                                          input logic             regWrM,
                                          input logic [REG_W-1:0] wrM,
                                          input logic             regWrW,
                                          input logic [REG_W-1:0] wrW);
        logic [1:0] sel;
        sel = 2'b00;
        if (regWrM && regMatch(wrM, src)) begin
            sel = 2'b10;
        end else if (regWrW && regMatch(wrW, src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Forwarding selects for the ALU and the decode-stage branch comparator.
    always_comb begin
        hz.ForwardAE = fwdSel(hz.RsE, hz.RegWriteM, hz.WriteRegM,
                              hz.RegWriteW, hz.WriteRegW);
        hz.ForwardBE = fwdSel(hz.RtE, hz.RegWriteM, hz.WriteRegM,
                              hz.RegWriteW, hz.WriteRegW);
        hz.ForwardAD = hz.RegWriteM && regMatch(hz.WriteRegM, hz.RsD);
        hz.ForwardBD = hz.RegWriteM && regMatch(hz.WriteRegM, hz.RtD);
    end

    // Data hazards seen from decode.
    always_comb begin
        lwStall     = 1'b0;
        branchStall = 1'b0;

        if (hz.MemtoRegE &&
            (regMatch(hz.WriteRegE, hz.RsD) || regMatch(hz.WriteRegE, hz.RtD))) begin
            lwStall = 1'b1;
        end

        // Branch compares in decode: an ALU result still in E, or a load
        // still in M, cannot be forwarded in time.
        if (hz.BranchD) begin
            if (hz.RegWriteE &&
                (regMatch(hz.WriteRegE, hz.RsD) || regMatch(hz.WriteRegE, hz.RtD))) begin
                branchStall = 1'b1;
            end
            if (hz.MemtoRegM &&
                (regMatch(hz.WriteRegM, hz.RsD) || regMatch(hz.WriteRegM, hz.RtD))) begin
                branchStall = 1'b1;
            end
        end

        hazStall = lwStall | branchStall;
    end

    // Mul/div sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdState <= MD_IDLE;
            cnt     <= '0;
        end else begin
            mdState <= mdStateNext;
            cnt     <= cntNext;
        end
    end

    // Mul/div sequencer next state and hold/done decode.
    always_comb begin
        mdStateNext = mdState;
        cntNext     = cnt;
        mdHold      = 1'b0;
        mdDone      = 1'b0;

        unique case (mdState)
            MD_IDLE: begin
                if (hz.MdStartE) begin
                    mdHold      = 1'b1;
                    mdStateNext = MD_BUSY;
                    cntNext     = hz.MdOpE ? DIV_LOAD : MUL_LOAD;
                end
            end
            MD_BUSY: begin
                // Start/op inputs are ignored here; the latency is committed.
                if (cnt != '0) begin
                    mdHold  = 1'b1;
                    cntNext = cnt - CNT_W'(1);
                end else begin
                    mdDone      = 1'b1;
                    mdStateNext = MD_IDLE;
                end
            end
            default: begin
                mdStateNext = MD_IDLE;
                cntNext     = '0;
            end
        endcase

        // While reset is asserted the sequencer is idle and must not hold.
        if (!rst_n) begin
            mdHold = 1'b0;
            mdDone = 1'b0;
        end
    end

    // Stall / flush fan-out. A held mul/div is never flushed out of execute.
    always_comb begin
        hz.StallF = hazStall | mdHold;
        hz.StallD = hazStall | mdHold;
        hz.StallE = mdHold;
        hz.FlushM = mdHold;
        hz.FlushE = hazStall & ~mdHold;
        hz.FlushD = hz.PCSrcD & ~(hazStall | mdHold);
        hz.MdBusy = ((mdState == MD_BUSY) && rst_n) | mdHold;
        hz.MdDone = mdDone;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl: a vector table for the combinational
// hazard rules, hand sequences for the mul/div hold, back-to-back issue and
// mid-operation reset, then random stimulus against a behavioural model.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int MUL_L = 4;
    localparam int DIV_L = 32;

    logic clk;
    logic rst_n;

    hazard_ctrl_if hz ();

    hazard_ctrl #(
        .MUL_LAT (MUL_L),
        .DIV_LAT (DIV_L),
        .CNT_W   (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Model of the sequencer: cycles elapsed since the start cycle (-1 idle).
    int mdAge = -1;
    int mdLat = 0;

    // exp bits: {ForwardAE, ForwardBE, ForwardAD, ForwardBD,
    //            StallF, StallD, StallE, FlushD, FlushE, FlushM}
    // flags  : {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, PCSrcD}
    typedef struct {
        string      name;
        logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
        logic [6:0] flags;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [13:0] actualOut();
        return {hz.ForwardAE, hz.ForwardBE, hz.ForwardAD, hz.ForwardBD,
                hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushM,
                hz.MdBusy, hz.MdDone};
    endfunction

    function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [1:0] modelFwdE(input logic [4:0] src);
        if (hz.RegWriteM && hit(hz.WriteRegM, src)) return 2'b10;
        if (hz.RegWriteW && hit(hz.WriteRegW, src)) return 2'b01;
        return 2'b00;
    endfunction

    // Expected outputs from the hazard rules and the elapsed-cycle count.
    function automatic logic [13:0] modelOut();
        bit lw, br, hold, busy, done, stl;
        lw = hz.MemtoRegE && (hit(hz.WriteRegE, hz.RsD) || hit(hz.WriteRegE, hz.RtD));
        br = hz.BranchD &&
             ((hz.RegWriteE && (hit(hz.WriteRegE, hz.RsD) || hit(hz.WriteRegE, hz.RtD))) ||
              (hz.MemtoRegM && (hit(hz.WriteRegM, hz.RsD) || hit(hz.WriteRegM, hz.RtD))));
        if (mdAge < 0) hold = rst_n && hz.MdStartE;
        else           hold = rst_n && (mdAge < mdLat);
        busy = rst_n && ((mdAge > 0) || hold);
        done = rst_n && (mdAge > 0) && (mdAge == mdLat);
        stl  = lw | br | hold;
        return {modelFwdE(hz.RsE), modelFwdE(hz.RtE),
                logic'(hz.RegWriteM && hit(hz.WriteRegM, hz.RsD)),
                logic'(hz.RegWriteM && hit(hz.WriteRegM, hz.RtD)),
                logic'(stl), logic'(stl), logic'(hold),
                logic'(hz.PCSrcD && !stl),
                logic'((lw | br) && !hold), logic'(hold),
                logic'(busy), logic'(done)};
    endfunction

    function automatic void modelAdvance();
        if (!rst_n) begin
            mdAge = -1;
        end else if (mdAge < 0) begin
            if (hz.MdStartE) begin
                mdAge = 1;
                mdLat = hz.MdOpE ? DIV_L : MUL_L;
            end
        end else if (mdAge == mdLat) begin
            mdAge = -1;
        end else begin
            mdAge++;
        end
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic tick();
        modelAdvance();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        hz.RsD = '0; hz.RtD = '0; hz.RsE = '0; hz.RtE = '0;
        hz.WriteRegE = '0; hz.WriteRegM = '0; hz.WriteRegW = '0;
        hz.RegWriteE = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
        hz.MemtoRegE = 1'b0; hz.MemtoRegM = 1'b0;
        hz.BranchD = 1'b0; hz.PCSrcD = 1'b0;
        hz.MdStartE = 1'b0; hz.MdOpE = 1'b0;
    endtask

    // One mul/div from its start cycle to release; MdStartE stays high the whole time.
    task automatic runMd(input string pfx, input logic op, input int lat);
        hz.MdStartE = 1'b1;
        hz.MdOpE    = op;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            checkBit($sformatf("%s_stallE_c%0d", pfx, c), hz.StallE, logic'(c < lat));
            checkBit($sformatf("%s_flushM_c%0d", pfx, c), hz.FlushM, logic'(c < lat));
            checkBit($sformatf("%s_stallF_c%0d", pfx, c), hz.StallF, logic'(c < lat));
            checkBit($sformatf("%s_busy_c%0d",   pfx, c), hz.MdBusy, 1'b1);
            checkBit($sformatf("%s_done_c%0d",   pfx, c), hz.MdDone, logic'(c == lat));
            tick();
        end
    endtask

    initial begin
        // Table of single-cycle hazard cases, sequencer idle.
        vecs[0]  = '{"fwdMem",      5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 5'd5, 5'd5, 7'b0110000, 12'b1010_0000_0000};
        vecs[1]  = '{"fwdWb",       5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 5'd5, 5'd5, 7'b0010000, 12'b0101_0000_0000};
        vecs[2]  = '{"fwdReg0",     5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 5'd0, 5'd0, 7'b0110000, 12'b0000_0000_0000};
        vecs[3]  = '{"fwdMixed",    5'd0, 5'd0, 5'd5, 5'd6, 5'd0, 5'd6, 5'd5, 7'b0110000, 12'b0110_0000_0000};
        vecs[4]  = '{"loadUse",     5'd0, 5'd8, 5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 7'b1001000, 12'b0000_0011_0010};
        vecs[5]  = '{"loadUseReg0", 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 7'b1001000, 12'b0000_0000_0000};
        vecs[6]  = '{"branchAluE",  5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 7'b1000010, 12'b0000_0011_0010};
        vecs[7]  = '{"pcSrcFlush",  5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 7'b0000001, 12'b0000_0000_0100};
        vecs[8]  = '{"pcSrcStall",  5'd0, 5'd8, 5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 7'b1001001, 12'b0000_0011_0010};
        vecs[9]  = '{"fwdDecode",   5'd7, 5'd9, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 7'b0100000, 12'b0000_1000_0000};
        vecs[10] = '{"branchLoadM", 5'd0, 5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 7'b0100110, 12'b0000_0111_0010};
        vecs[11] = '{"branchAluM",  5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 7'b0100010, 12'b0000_1000_0000};
        vecs[12] = '{"branchNoWrE", 5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 7'b0000010, 12'b0000_0000_0000};
        vecs[13] = '{"branchWbOnly",5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 7'b0010010, 12'b0000_0000_0000};
        vecs[14] = '{"allReg0",     5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 7'b1111110, 12'b0000_0000_0000};

        // Reset state.
        rst_n = 1'b1;
        clearInputs();
        #1 rst_n = 1'b0;
        #1 check("reset_outputs", actualOut(), 14'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Combinational hazard table.
        for (int i = 0; i < 15; i++) begin
            clearInputs();
            hz.RsD = vecs[i].rsD; hz.RtD = vecs[i].rtD;
            hz.RsE = vecs[i].rsE; hz.RtE = vecs[i].rtE;
            hz.WriteRegE = vecs[i].wrE; hz.WriteRegM = vecs[i].wrM; hz.WriteRegW = vecs[i].wrW;
            {hz.RegWriteE, hz.RegWriteM, hz.RegWriteW, hz.MemtoRegE,
             hz.MemtoRegM, hz.BranchD, hz.PCSrcD} = vecs[i].flags;
            @(negedge clk);
            check(vecs[i].name, actualOut(), {vecs[i].exp, 2'b00});
            tick();
        end

        // Multiply, then a back-to-back multiply entering on the cycle after release.
        clearInputs();
        runMd("mul", 1'b0, MUL_L);
        runMd("mulB2B", 1'b0, MUL_L);
        hz.MdStartE = 1'b0;
        @(negedge clk);
        check("mulIdleAfter", actualOut(), 14'd0);
        tick();

        // Divide with a load-use waiting in decode: never flushed while held.
        clearInputs();
        hz.MdStartE = 1'b1; hz.MdOpE = 1'b1;
        hz.MemtoRegE = 1'b1; hz.RegWriteE = 1'b1; hz.WriteRegE = 5'd8; hz.RtD = 5'd8;
        for (int c = 0; c <= DIV_L; c++) begin
            @(negedge clk);
            if (c < DIV_L) begin
                checkBit($sformatf("div_flushE_c%0d", c), hz.FlushE, 1'b0);
                checkBit($sformatf("div_stallE_c%0d", c), hz.StallE, 1'b1);
                checkBit($sformatf("div_done_c%0d", c), hz.MdDone, 1'b0);
            end else begin
                checkBit("div_release_done",   hz.MdDone, 1'b1);
                checkBit("div_release_stallE", hz.StallE, 1'b0);
                checkBit("div_release_flushE", hz.FlushE, 1'b1);
                checkBit("div_release_stallD", hz.StallD, 1'b1);
            end
            tick();
        end
        hz.MdStartE = 1'b0;
        @(negedge clk);
        checkBit("div_after_flushE", hz.FlushE, 1'b1);
        checkBit("div_after_busy",   hz.MdBusy, 1'b0);
        tick();

        // Reset in cycle 10 of a divide.
        clearInputs();
        hz.MdStartE = 1'b1; hz.MdOpE = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        checkBit("divRst_busy_before", hz.MdBusy, 1'b1);
        #1;
        rst_n = 1'b0;
        hz.MdStartE = 1'b0;
        mdAge = -1;
        #1;
        checkBit("divRst_busy",   hz.MdBusy, 1'b0);
        checkBit("divRst_stallE", hz.StallE, 1'b0);
        check("divRst_outputs", actualOut(), 14'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("postReset_idle", actualOut(), 14'd0);
        tick();
        runMd("mulPostRst", 1'b0, MUL_L);
        hz.MdStartE = 1'b0;
        tick();

        // Random stimulus against the model.
        rst_n = 1'b0;
        clearInputs();
        mdAge = -1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            rst_n = 1'b1;
            hz.RsD = 5'($urandom_range(0, 3)); hz.RtD = 5'($urandom_range(0, 3));
            hz.RsE = 5'($urandom_range(0, 3)); hz.RtE = 5'($urandom_range(0, 3));
            hz.WriteRegE = 5'($urandom_range(0, 3));
            hz.WriteRegM = 5'($urandom_range(0, 3));
            hz.WriteRegW = 5'($urandom_range(0, 3));
            {hz.RegWriteE, hz.RegWriteM, hz.RegWriteW, hz.MemtoRegE,
             hz.MemtoRegM, hz.BranchD, hz.PCSrcD} = 7'($urandom);
            hz.MdStartE = ($urandom_range(0, 5) == 0);
            hz.MdOpE    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                hz.MdStartE = 1'b0;
                mdAge = -1;
            end
            @(negedge clk);
            check($sformatf("random_%0d", i), actualOut(), modelOut());
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
